// File: rtl/lsu_bus_master_if.sv
// Data-memory port between the LSU (master) and the memory (slave).
interface lsu_bus_master_if #(parameter int WIDTH = 32);
  logic               mem_valid;
  logic               mem_ready;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH/8-1:0] mem_wstrb;
  logic               mem_rvalid;
  logic [WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator: aligns EXU requests onto the word bus with
// byte strobes and returns extended load data, with misalign and timeout errors.
module lsu_bus_master #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  lsu_bus_master_if.master mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       lo_q;
  logic             we_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  logic             mem_we_q, err_q;

  logic             bad, timeout, got_rsp;
  logic [3:0]       strb_n;
  logic [WIDTH-1:0] wd_n, lane, ext;

  always_comb begin
    bad = 1'b0;
    case (req_op)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = req_addr[0];
      3'b010:         bad = (req_addr[1:0] != 2'b00);
      default:        bad = 1'b1;
    endcase
  end

  always_comb begin
    strb_n = 4'b1111;
    wd_n   = req_wdata;
    case (req_op[1:0])
      2'b00: begin strb_n = 4'b0001 << req_addr[1:0];        wd_n = {4{req_wdata[7:0]}};  end
      2'b01: begin strb_n = 4'b0011 << {req_addr[1], 1'b0};  wd_n = {2{req_wdata[15:0]}}; end
      default: ;
    endcase
  end

  // Load data is shifted down to the addressed lane before extension.
  always_comb begin
    lane = mem.mem_rdata >> {lo_q, 3'b000};
    ext  = lane;
    case (op_q)
      3'b000:  ext = {{24{lane[7]}},  lane[7:0]};
      3'b100:  ext = {24'b0,          lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext = {16'b0,          lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign timeout = (cnt_q >= 8'(TIMEOUT_CYCLES - 1));
  assign got_rsp = (state_q == WAIT) && mem.mem_rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = bad ? RESP : REQ;
      REQ:  if (timeout) state_d = RESP;
            else if (mem.mem_ready) state_d = WAIT;
      WAIT: if (mem.mem_rvalid || timeout) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; lo_q <= '0; we_q <= 1'b0; cnt_q <= '0;
      addr_q <= '0; wdata_q <= '0; wstrb_q <= '0; mem_we_q <= 1'b0;
      rdata_q <= '0; err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          lo_q    <= req_addr[1:0];
          we_q    <= req_we;
          cnt_q   <= '0;
          err_q   <= bad;
          rdata_q <= '0;
          // Rejected requests never touch the bus registers.
          if (!bad) begin
            addr_q   <= {req_addr[WIDTH-1:2], 2'b00};
            mem_we_q <= req_we;
            wstrb_q  <= req_we ? strb_n : 4'b0000;
            wdata_q  <= wd_n;
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (state_d == RESP) begin
            err_q   <= !got_rsp;
            rdata_q <= (got_rsp && !we_q) ? ext : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem.mem_valid = (state_q == REQ);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized bench for lsu_bus_master against a size/offset arithmetic reference model.
module tb_lsu_bus_master;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  int          n_chk = 0, n_fail = 0, hs_cnt = 0, hs_exp = 0;

  lsu_bus_master_if #(.WIDTH(32)) mb();

  lsu_bus_master #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem(mb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mb.mem_valid && mb.mem_ready) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_size(input logic [2:0] op);
    case (op & 3'd3)
      3'd0:    return 1;
      3'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_bad(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3 || op > 5) return 1'b1;
    return (addr % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit we, input logic [2:0] op, input logic [31:0] addr);
    if (!we) return 4'b0;
    return 4'(((1 << m_size(op)) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (m_size(op))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int sz = m_size(op);
    longint unsigned v, mask;
    if (sz == 4) return rd;
    v    = {32'b0, rd} >> (8 * (addr % 4));
    mask = (64'd1 << (8 * sz)) - 1;
    v    = v & mask;
    if (op < 4 && v >= (mask + 1) / 2) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic chk_bus(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
    chk("mem_valid", 32'(mb.mem_valid), 32'd1);
    chk("mem_addr",  mb.mem_addr, addr & ~32'd3);
    chk("mem_we",    32'(mb.mem_we), 32'(we));
    chk("mem_wstrb", 32'(mb.mem_wstrb), 32'(m_strb(we, op, addr)));
    if (we) chk("mem_wdata", mb.mem_wdata, m_wdata(op, wd));
  endtask

  task automatic accept(input bit we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
  endtask

  task automatic finish_resp(input logic [31:0] exp_rd, input bit exp_err, input int rlat);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err",   32'(resp_err), 32'(exp_err));
    chk("resp_rdata", resp_rdata, exp_rd);
    for (int i = 0; i < rlat; i++) begin
      resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_hold_v", 32'(resp_valid), 32'd1);
      chk("resp_hold_d", resp_rdata, exp_rd);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'd0);
    chk("ready_again", 32'(req_ready), 32'd1);
    chk("hs_count", 32'(hs_cnt), 32'(hs_exp));
  endtask

  // One full transaction; junk drives an rvalid during the request handshake cycle.
  task automatic txn(input bit we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int mlat, input int rlat, input bit junk);
    mb.mem_ready = 1'b0;
    accept(we, op, addr, wd);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (m_bad(op, addr)) begin
      chk("bad_no_bus", 32'(mb.mem_valid), 32'd0);
      finish_resp(32'd0, 1'b1, rlat);
      return;
    end
    chk_bus(we, op, addr, wd);
    for (int i = 0; i < mlat; i++) begin
      @(negedge clk);
      chk_bus(we, op, addr, wd);
    end
    mb.mem_ready = 1'b1;
    if (junk) begin mb.mem_rvalid = 1'b1; mb.mem_rdata = ~rd; end
    hs_exp++;
    @(negedge clk);
    mb.mem_ready = 1'b0;
    chk("wait_no_valid", 32'(mb.mem_valid), 32'd0);
    chk("wait_no_resp",  32'(resp_valid), 32'd0);
    mb.mem_rvalid = 1'b1; mb.mem_rdata = rd;
    @(negedge clk);
    mb.mem_rvalid = 1'b0; mb.mem_rdata = $urandom;
    finish_resp(we ? 32'd0 : m_load(op, addr, rd), 1'b0, rlat);
  endtask

  task automatic timeout_txn(input bit give_ready);
    int k;
    accept(1'b0, 3'b010, 32'h8000_0010, 32'd0);
    chk("to_req", 32'(mb.mem_valid), 32'd1);
    mb.mem_ready = give_ready;
    if (give_ready) hs_exp++;
    k = 1;
    while (!resp_valid && k < 400) begin
      @(negedge clk);
      mb.mem_ready = 1'b0;
      k++;
    end
    chk("to_latency", 32'(k), 32'(TO + 1));
    chk("to_mem_drop", 32'(mb.mem_valid), 32'd0);
    mb.mem_rvalid = 1'b1; mb.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mb.mem_rvalid = 1'b0;
    finish_resp(32'd0, 1'b1, 1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    mb.mem_ready = 1'b0; mb.mem_rvalid = 1'b0; mb.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_valid",  32'(mb.mem_valid), 32'd0);
    chk("rst_mem_we",     32'(mb.mem_we), 32'd0);
    chk("rst_mem_addr",   mb.mem_addr, 32'd0);
    chk("rst_mem_wdata",  mb.mem_wdata, 32'd0);
    chk("rst_mem_wstrb",  32'(mb.mem_wstrb), 32'd0);
    rst = 1'b0;

    // directed vectors
    txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lb_value", resp_rdata, 32'hFFFF_FF80);
    txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h8001_0000, 0, 0, 1'b0);
    chk("lhu_value", resp_rdata, 32'h0000_8001);
    txn(1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'h8001_0000, 0, 0, 1'b0);
    chk("lh_value", resp_rdata, 32'hFFFF_8001);
    txn(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'd0, 0, 0, 1'b0);
    txn(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    txn(1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h5555_5555, 3, 2, 1'b1);

    timeout_txn(1'b1);
    timeout_txn(1'b0);

    // reset while waiting for the bus response
    accept(1'b0, 3'b010, 32'h8000_0020, 32'd0);
    mb.mem_ready = 1'b1; hs_exp++;
    @(negedge clk);
    mb.mem_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_mem_valid", 32'(mb.mem_valid), 32'd0);
    chk("rstw_mem_addr",  mb.mem_addr, 32'd0);
    mb.mem_rvalid = 1'b1; mb.mem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    mb.mem_rvalid = 1'b0;
    chk("rstw_late_rvalid", 32'(resp_valid), 32'd0);
    chk("rstw_idle", 32'(req_ready), 32'd1);

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && (op == 3 || op > 5)) op = 3'b010;
      a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      if ($urandom_range(0, 2) != 0) a = a & ~32'(m_size(op) - 1);
      txn(1'($urandom), op, a, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
